// File: rtl/max7219_pkg.sv
// Shared register map, state encodings and source codes for the MAX7219 frame scheduler.
package max7219_pkg;

  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DIGIT1    = 8'h02;
  localparam logic [7:0] REG_DIGIT2    = 8'h03;
  localparam logic [7:0] REG_DIGIT3    = 8'h04;
  localparam logic [7:0] REG_DIGIT4    = 8'h05;
  localparam logic [7:0] REG_DIGIT5    = 8'h06;
  localparam logic [7:0] REG_DIGIT6    = 8'h07;
  localparam logic [7:0] REG_DIGIT7    = 8'h08;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ISSUE,
    ST_ACKW,
    ST_DONEW,
    ST_IDLE,
    ST_CFG
  } state_t;

  // Scheduler-level phase; the per-write ISSUE/ACKW/DONEW steps live in the handshake.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_INIT,
    PH_CFG,
    PH_FRAME
  } phase_t;

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_PORT0 = 2'b01;
  localparam logic [1:0] SRC_PORT1 = 2'b10;
  localparam logic [1:0] SRC_CFG   = 2'b11;

endpackage

// File: rtl/max7219_wr_hs.sv
// Single register write handshake to the MAX7219 serial engine: strobe, wait for busy, wait for busy to fall.
module max7219_wr_hs
  import max7219_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       ready,
  output logic       done,
  output logic       timeout,
  output logic       str,
  input  logic       busy,
  output logic [7:0] addr,
  output logic [7:0] data
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            busy_q;
  logic            cnt_last;

  assign cnt_last = (cnt == CW'(ACK_TIMEOUT - 1));

  always_ff @(posedge sys_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (go && !busy) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_ACKW;
      ST_ACKW: begin
        if (busy)          state_nxt = ST_DONEW;
        else if (cnt_last) state_nxt = ST_IDLE;
      end
      ST_DONEW: if (busy_q && !busy) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready   = (state == ST_IDLE) && !busy;
    str     = (state == ST_ISSUE);
    done    = (state == ST_DONEW) && busy_q && !busy;
    timeout = (state == ST_ACKW) && !busy && cnt_last;
  end

  // A new write is held off while a transfer left over from before reset is still shifting.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      addr   <= 8'h00;
      data   <= 8'h00;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy;
      if (state == ST_IDLE && go && !busy) begin
        addr <= wr_addr;
        data <= wr_data;
      end
      if (state == ST_ACKW) cnt <= cnt + CW'(1);
      else                  cnt <= '0;
    end
  end

endmodule

// File: rtl/max7219_frame_sched.sv
// Arbitrates two 8-digit frame sources onto one MAX7219 write engine, with init, intensity updates and periodic re-init.
module max7219_frame_sched
  import max7219_pkg::*;
#(
  parameter int         ACK_TIMEOUT   = 64,
  parameter int         REINIT_FRAMES = 256,
  parameter logic [7:0] DECODE_MODE   = 8'hFF,
  parameter logic [7:0] SCAN_LIMIT    = 8'h07
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [63:0] frame0,
  output logic        ack0,
  input  logic        req1,
  input  logic [63:0] frame1,
  output logic        ack1,
  input  logic [3:0]  intensity,
  input  logic        intensity_upd,
  output logic        str,
  input  logic        busy,
  output logic [7:0]  addr,
  output logic [7:0]  data,
  output logic        init_done,
  output logic [1:0]  active_src,
  output logic        err_timeout
);

  localparam int            CW      = $clog2(REINIT_FRAMES + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(REINIT_FRAMES);

  phase_t        phase, phase_nxt;
  logic [2:0]    idx;
  logic          wr_out;
  logic [CW-1:0] frame_cnt;
  logic          upd_pend;
  logic [63:0]   frame_latch;
  logic          src1, src_nxt;
  logic          hs_ready, hs_done, hs_timeout;
  logic          fin, last, go, reinit_due, grant0, grant1;
  logic [7:0]    wr_addr, wr_data;

  max7219_wr_hs #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_hs (
    .sys_clk (sys_clk),
    .rst     (rst),
    .go      (go),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .ready   (hs_ready),
    .done    (hs_done),
    .timeout (hs_timeout),
    .str     (str),
    .busy    (busy),
    .addr    (addr),
    .data    (data)
  );

  assign fin        = hs_done | hs_timeout;
  assign reinit_due = (REINIT_FRAMES != 0) && (frame_cnt == CNT_MAX);
  assign grant0     = (phase == PH_IDLE) && !reinit_due && !upd_pend && req0;
  assign grant1     = (phase == PH_IDLE) && !reinit_due && !upd_pend && !req0 && req1;
  assign src_nxt    = (grant0 || grant1) ? grant1 : src1;

  always_ff @(posedge sys_clk) begin
    if (rst) phase <= PH_INIT;
    else     phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_IDLE: begin
        if (reinit_due)            phase_nxt = PH_INIT;
        else if (upd_pend)         phase_nxt = PH_CFG;
        else if (grant0 || grant1) phase_nxt = PH_FRAME;
      end
      PH_INIT:  if (fin && last) phase_nxt = PH_IDLE;
      PH_CFG:   if (fin)         phase_nxt = PH_IDLE;
      PH_FRAME: if (fin && last) phase_nxt = PH_IDLE;
      default:  phase_nxt = PH_IDLE;
    endcase
  end

  always_comb begin
    go      = 1'b0;
    last    = 1'b0;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    case (phase)
      PH_INIT: begin
        go   = !wr_out && hs_ready;
        last = (idx == 3'd4);
        case (idx)
          3'd0:    begin wr_addr = REG_TEST;      wr_data = 8'h00;            end
          3'd1:    begin wr_addr = REG_DECODE;    wr_data = DECODE_MODE;      end
          3'd2:    begin wr_addr = REG_INTENSITY; wr_data = {4'h0, intensity}; end
          3'd3:    begin wr_addr = REG_SCANLIMIT; wr_data = SCAN_LIMIT;       end
          default: begin wr_addr = REG_SHUTDOWN;  wr_data = 8'h01;            end
        endcase
      end
      PH_CFG: begin
        go      = !wr_out && hs_ready;
        last    = 1'b1;
        wr_addr = REG_INTENSITY;
        wr_data = {4'h0, intensity};
      end
      PH_FRAME: begin
        go      = !wr_out && hs_ready;
        last    = (idx == 3'd7);
        wr_addr = REG_DIGIT0 + {5'b00000, idx};
        wr_data = frame_latch[{idx, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  // Control state: item index, outstanding-write flag, counters and status flags.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      idx         <= 3'd0;
      wr_out      <= 1'b0;
      frame_cnt   <= '0;
      upd_pend    <= 1'b0;
      init_done   <= 1'b0;
      err_timeout <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      src1        <= 1'b0;
      active_src  <= SRC_NONE;
    end else begin
      ack0 <= grant0;
      ack1 <= grant1;
      src1 <= src_nxt;
      if (go)       wr_out <= 1'b1;
      else if (fin) wr_out <= 1'b0;
      if (fin) idx <= last ? 3'd0 : idx + 3'd1;
      if (hs_timeout) err_timeout <= 1'b1;
      if (fin && last && phase == PH_INIT) begin
        init_done <= 1'b1;
        frame_cnt <= '0;
      end
      if (fin && last && phase == PH_FRAME && frame_cnt != CNT_MAX)
        frame_cnt <= frame_cnt + CW'(1);
      // A fresh request wins over the clear in the same cycle.
      if (intensity_upd)
        upd_pend <= 1'b1;
      else if ((phase == PH_CFG && go) || (phase == PH_INIT && fin && last))
        upd_pend <= 1'b0;
      case (phase_nxt)
        PH_INIT, PH_CFG: active_src <= SRC_CFG;
        PH_FRAME:        active_src <= src_nxt ? SRC_PORT1 : SRC_PORT0;
        default:         active_src <= SRC_NONE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (grant0)      frame_latch <= frame0;
    else if (grant1) frame_latch <= frame1;
  end

endmodule

// File: tb/tb_max7219_frame_sched.sv
// Directed bench for the MAX7219 frame scheduler with a simple write-engine model that logs every strobed write.
module tb_max7219_frame_sched;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, intensity_upd = 1'b0, busy = 1'b0;
  logic [63:0] frame0 = 64'h0, frame1 = 64'h0;
  logic [3:0]  intensity = 4'h3;
  logic        ack0, ack1, str, init_done, err_timeout;
  logic [7:0]  addr, data;
  logic [1:0]  active_src;

  int n_chk = 0;
  int n_fail = 0;

  logic       hang = 1'b0;
  logic       eng_start = 1'b0;
  int         eng_cnt = 0;
  logic [7:0] log_a[$];
  logic [7:0] log_d[$];

  logic [7:0] E_F0 [8] = '{8'h02, 8'h03, 8'h0A, 8'h04, 8'h05, 8'h0A, 8'h06, 8'h07};
  logic [7:0] E_F1 [8] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
  logic [7:0] E_F2 [8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
  logic [7:0] E_F3 [8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};

  always #5 sys_clk = ~sys_clk;

  max7219_frame_sched #(
    .ACK_TIMEOUT(64), .REINIT_FRAMES(2), .DECODE_MODE(8'hFF), .SCAN_LIMIT(8'h07)
  ) dut (
    .sys_clk(sys_clk), .rst(rst),
    .req0(req0), .frame0(frame0), .ack0(ack0),
    .req1(req1), .frame1(frame1), .ack1(ack1),
    .intensity(intensity), .intensity_upd(intensity_upd),
    .str(str), .busy(busy), .addr(addr), .data(data),
    .init_done(init_done), .active_src(active_src), .err_timeout(err_timeout)
  );

  // Engine: busy rises one cycle after str and stays high 16 cycles; hang keeps it low.
  always @(posedge sys_clk) begin
    if (str) begin
      log_a.push_back(addr);
      log_d.push_back(data);
    end
    if (!hang) begin
      eng_start <= str;
      if (eng_start) begin
        busy    <= 1'b1;
        eng_cnt <= 16;
      end else if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) busy <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int t = 0;
    while (log_a.size() < n && t < budget) begin
      @(negedge sys_clk);
      t++;
    end
    chk(tag, 64'(log_a.size()), 64'(n));
  endtask

  task automatic wait_ack(input int budget);
    int t = 0;
    while (!(ack0 || ack1) && t < budget) begin
      @(negedge sys_clk);
      t++;
    end
  endtask

  task automatic wait_init(input string tag, input int budget);
    int t = 0;
    while (!init_done && t < budget) begin
      @(negedge sys_clk);
      t++;
    end
    chk(tag, 64'(init_done), 64'd1);
  endtask

  task automatic chk_entry(input string tag, input int i, input logic [7:0] ea, input logic [7:0] ed);
    if (i < log_a.size()) begin
      chk($sformatf("%s_a%0d", tag, i), 64'(log_a[i]), 64'(ea));
      chk($sformatf("%s_d%0d", tag, i), 64'(log_d[i]), 64'(ed));
    end else begin
      chk($sformatf("%s_missing%0d", tag, i), 64'(log_a.size()), 64'(i + 1));
    end
  endtask

  task automatic chk_init(input string tag, input int base, input logic [7:0] ib);
    chk_entry(tag, base + 0, 8'h0F, 8'h00);
    chk_entry(tag, base + 1, 8'h09, 8'hFF);
    chk_entry(tag, base + 2, 8'h0A, ib);
    chk_entry(tag, base + 3, 8'h0B, 8'h07);
    chk_entry(tag, base + 4, 8'h0C, 8'h01);
  endtask

  task automatic chk_frame(input string tag, input int base, input logic [7:0] e [8]);
    for (int k = 0; k < 8; k++) chk_entry(tag, base + k, 8'(k + 1), e[k]);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_str"},  64'(str),         64'd0);
    chk({tag, "_ack0"}, 64'(ack0),        64'd0);
    chk({tag, "_ack1"}, 64'(ack1),        64'd0);
    chk({tag, "_addr"}, 64'(addr),        64'd0);
    chk({tag, "_data"}, 64'(data),        64'd0);
    chk({tag, "_idn"},  64'(init_done),   64'd0);
    chk({tag, "_src"},  64'(active_src),  64'd0);
    chk({tag, "_err"},  64'(err_timeout), 64'd0);
  endtask

  initial begin
    int t;
    int n;
    repeat (3) @(negedge sys_clk);
    chk_reset_vals("rst0");
    rst = 1'b0;
    @(negedge sys_clk);
    chk("init_src", 64'(active_src), 64'd3);
    wait_init("init_done", 600);
    wait_log("init_n", 5, 50);
    chk_init("init", 0, 8'h03);
    chk("init_err", 64'(err_timeout), 64'd0);
    log_a.delete(); log_d.delete();

    // Both ports requesting: port 0 first, then port 1, then automatic re-init after 2 frames.
    frame0 = 64'h0706_0A05_040A_0302;
    frame1 = 64'h1817_1615_1413_1211;
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(50);
    chk("arb_ack0", 64'(ack0), 64'd1);
    chk("arb_ack1", 64'(ack1), 64'd0);
    chk("arb_src0", 64'(active_src), 64'd1);
    req0 = 1'b0;
    frame0 = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge sys_clk);
    chk("ack0_pulse", 64'(ack0), 64'd0);
    wait_ack(400);
    chk("arb2_ack1", 64'(ack1), 64'd1);
    chk("arb2_src1", 64'(active_src), 64'd2);
    req1 = 1'b0;
    wait_log("frames_n", 21, 1000);
    chk_frame("f0", 0, E_F0);
    chk_frame("f1", 8, E_F1);
    chk_init("reinit", 16, 8'h03);
    log_a.delete(); log_d.delete();

    // Intensity update mid-frame lands between frames.
    intensity = 4'h9;
    frame0 = 64'h2827_2625_2423_2221;
    frame1 = 64'h3837_3635_3433_3231;
    req0 = 1'b1;
    wait_ack(300);
    chk("upd_ack0", 64'(ack0), 64'd1);
    req0 = 1'b0; req1 = 1'b1;
    wait_log("upd_mid", 3, 200);
    intensity_upd = 1'b1;
    @(negedge sys_clk);
    intensity_upd = 1'b0;
    wait_ack(600);
    chk("upd_ack1", 64'(ack1), 64'd1);
    req1 = 1'b0;
    wait_log("upd_n", 22, 1500);
    chk_frame("f2", 0, E_F2);
    chk_entry("cfg", 8, 8'h0A, 8'h09);
    chk_frame("f3", 9, E_F3);
    chk_init("reinit2", 17, 8'h09);
    log_a.delete(); log_d.delete();

    // Reset during the digit-4 write.
    frame0 = 64'h0807_0605_0403_0201;
    req0 = 1'b1;
    wait_ack(300);
    chk("rstf_ack0", 64'(ack0), 64'd1);
    req0 = 1'b0;
    wait_log("rst_d4", 4, 300);
    chk_entry("rst_d4", 3, 8'h04, 8'h04);
    rst = 1'b1;
    @(negedge sys_clk);
    chk_reset_vals("rst1");
    rst = 1'b0;
    log_a.delete(); log_d.delete();
    wait_log("rst_first_n", 1, 100);
    chk_entry("rst_first", 0, 8'h0F, 8'h00);
    wait_init("rst_init_done", 600);

    // Engine never answers: every write times out, init still completes.
    hang = 1'b1;
    rst = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("to_err_rst", 64'(err_timeout), 64'd0);
    rst = 1'b0;
    log_a.delete(); log_d.delete();
    t = 0;
    while (!str && t < 20) begin
      @(negedge sys_clk);
      t++;
    end
    chk("to_str", 64'(str), 64'd1);
    n = 0;
    while (!err_timeout && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    chk("to_latency", 64'(n), 64'd65);
    @(negedge sys_clk);
    chk("to_next_str", 64'(str), 64'd1);
    wait_init("to_init_done", 800);
    chk("to_err", 64'(err_timeout), 64'd1);
    chk("to_n", 64'(log_a.size()), 64'd5);
    chk_entry("to_last", 4, 8'h0C, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/max7219_frame_sched.md
Name: max7219_frame_sched

Overview:
- Controller and arbiter in front of the MAX7219 serial write engine (str/busy/address/data interface) used by the IRIG-B time display.
- After reset it runs the chip-initialisation register sequence.
- It then shares the engine between two frame requesters: live decoded IRIG time (port 0) and free-running holdover time (port 1). Each accepted request writes one whole 8-digit frame.
- It also applies runtime intensity changes and periodic re-initialisation between frames, never in the middle of one.

Parameters:
- ACK_TIMEOUT, 64: max sys_clk cycles from str to busy rising before the write is abandoned.
- REINIT_FRAMES, 256: frames between automatic re-init sequences; 0 disables re-init.
- DECODE_MODE, 8'hFF: value written to register 0x09.
- SCAN_LIMIT, 8'h07: value written to register 0x0B.

Ports:
- sys_clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  live-time frame request, level.
- frame0  in  64  live digits; byte i is digit register i+1.
- ack0  out  1  one-cycle pulse when the req0 frame is latched.
- req1  in  1  holdover frame request, level.
- frame1  in  64  holdover digits, same layout as frame0.
- ack1  out  1  one-cycle pulse when the req1 frame is latched.
- intensity  in  4  brightness for register 0x0A.
- intensity_upd  in  1  pulse; rewrite intensity before the next frame.
- str  out  1  one-cycle start strobe to the write engine.
- busy  in  1  engine busy; high during serial shift.
- addr  out  8  MAX7219 register address; stable from str until busy falls.
- data  out  8  register data; stable from str until busy falls.
- init_done  out  1  high after the first init sequence completes.
- active_src  out  2  2'b00 none, 2'b01 port0, 2'b10 port1, 2'b11 init/config.
- err_timeout  out  1  sticky; set on any ack timeout; cleared only by rst.

Behaviour:
- Reset values: str=0, ack0=0, ack1=0, addr=0, data=0, init_done=0, active_src=0, err_timeout=0, frame counter=0, upd_pend=0. The FSM enters INIT.
- Reset asserted mid-operation aborts immediately. Any engine transfer in progress is left to finish on its own; the FSM restarts INIT after reset releases.
- States: INIT, ISSUE, ACKW, DONEW, IDLE, CFG.
- Write handshake, common to all register writes:
  - ISSUE: drive addr/data, str=1 for exactly one cycle, go to ACKW.
  - ACKW: when busy=1, go to DONEW. If ACK_TIMEOUT cycles pass with busy=0, set err_timeout, drop the write and advance to the next item.
  - DONEW: wait for busy=0, sampled as a 1->0 transition; then advance.
  - Minimum write latency is 3 cycles plus the engine busy time. Only one write is ever outstanding.
- Init list, in order: (0x0F,0x00), (0x09,DECODE_MODE), (0x0A,{4'h0,intensity}), (0x0B,SCAN_LIMIT), (0x0C,0x01). When it completes: init_done=1, frame counter=0, upd_pend=0, go to IDLE.
- IDLE priority, highest first:
  1. Re-init due (REINIT_FRAMES≠0 and counter==REINIT_FRAMES) -> INIT.
  2. upd_pend -> CFG: one write (0x0A,intensity), clear upd_pend, return to IDLE.
  3. req0 -> latch frame0, ack0 pulse, active_src=01.
  4. req1 -> latch frame1, ack1 pulse, active_src=10.
- ack is issued in the same cycle the frame is latched.
- Frame transfer: addresses 0x01..0x08 in ascending order. Data for address k is frame_latch[8k-1:8k-8]. Input frame changes after latch are ignored.
- At frame end: counter increments, saturating at REINIT_FRAMES; active_src=00; return to IDLE. Back-to-back frames are possible with one IDLE cycle between them.
- intensity_upd sets upd_pend in any state, including the same cycle as its clearing write; set wins. Multiple pulses merge into one.
- A request that is held but not granted stays pending; no starvation guard is required (port0 is the authority).
- active_src=11 during INIT and CFG.

Decomposition:
- Shared package max7219_pkg:
  - register address constants REG_DIGIT0..7=0x01..0x08, REG_DECODE=0x09, REG_INTENSITY=0x0A, REG_SCANLIMIT=0x0B, REG_SHUTDOWN=0x0C, REG_TEST=0x0F;
  - the state enum;
  - the active_src encodings.
- One sub-module, max7219_wr_hs: the ISSUE/ACKW/DONEW handshake with its timeout counter, exposing go/done/timeout to the scheduler.

Test Plan:
- Reset release with an engine model of busy 1 cycle after str, high 16 cycles -> writes are exactly (0F,00),(09,FF),(0A,0x),(0B,07),(0C,01), then init_done=1.
- req0 and req1 both held, frame0=64'h0706_0A05_040A_0302 -> ack0 only; addr 01..08 carry data 02,03,0A,04,05,0A,06,07; then req1 is served next.
- intensity=4'h9 with an intensity_upd pulse during a frame -> the frame completes intact, then one write (0A,09) occurs before the next frame.
- Engine never raises busy -> err_timeout=1 after 64 cycles per write; init still completes and init_done=1.
- REINIT_FRAMES=2, req1 held -> two frames, then a full init sequence, then frames resume.
- rst pulsed during the digit-4 write -> all outputs return to reset values next cycle; init restarts from (0F,00).
